// File: rtl/mul_control.sv
// mul_control: shift-add multiplier sequencer (load / add / shift pulses).
// Optional abort input enabled by defining MUL_CTRL_ABORT_EN.
module mul_control #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             lsb,
`ifdef MUL_CTRL_ABORT_EN
  input  logic             abort,
`endif
  output logic             wrctrl,
  output logic             strctrl,
  output logic             shrctrl,
  output logic             ready,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TEST,
    ADD,
    SHIFT,
    DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (run) state_d = LOAD;
      end
      LOAD: begin
        count_d = '0;
        state_d = TEST;
      end
      TEST: begin
        state_d = lsb ? ADD : SHIFT;
      end
      ADD: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        count_d = count_q + CNT_W'(1);
        state_d = (count_q == LAST) ? DONE : TEST;
      end
      DONE: begin
        if (run) state_d = LOAD;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
`ifdef MUL_CTRL_ABORT_EN
    // abort overrides any transition while the sequence is active
    if (abort && busy) begin
      state_d = IDLE;
      count_d = '0;
    end
`endif
  end

  assign wrctrl  = (state_q == LOAD);
  assign strctrl = (state_q == ADD);
  assign shrctrl = (state_q == SHIFT);
  assign ready   = (state_q == DONE);
  assign busy    = (state_q == LOAD) ||
                   (state_q == TEST) ||
                   (state_q == ADD)  ||
                   (state_q == SHIFT);
  assign count   = count_q;

endmodule

// File: tb/tb_mul_control.sv
// tb_mul_control: scoreboard bench with a behavioural product register.
// Build with MUL_CTRL_ABORT_EN to exercise abort.
module tb_mul_control;

  localparam int W  = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          run = 1'b0;
  logic          lsb;
  logic          wrctrl, strctrl, shrctrl;
  logic          ready, busy;
  logic [CW-1:0] count;
`ifdef MUL_CTRL_ABORT_EN
  logic          abort = 1'b0;
`endif

  mul_control #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .lsb     (lsb),
`ifdef MUL_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .wrctrl  (wrctrl),
    .strctrl (strctrl),
    .shrctrl (shrctrl),
    .ready   (ready),
    .busy    (busy),
    .count   (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int prod;
    int lat;
    int adds;
    int t0;
  } exp_t;

  exp_t     sb[$];
  int       total = 0;
  int       bad = 0;
  int       cyc = 0;
  logic [W-1:0]   mcand = '0;
  logic [W-1:0]   mplier = '0;
  logic [2*W:0]   prod = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // product register driven by the DUT's control pulses
  always @(posedge clk) begin
    if (wrctrl)
      prod <= {{(W+1){1'b0}}, mplier};
    else if (strctrl)
      prod <= prod + ({{(W+1){1'b0}}, mcand} << W);
    else if (shrctrl)
      prod <= prod >> 1;
  end
  assign lsb = prod[0];

  task automatic chk(string nm, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  int   n_str = 0, n_shr = 0;
  logic rdy_prev = 1'b0;

  always @(negedge clk) begin
    if (!rst) begin
      rdy_prev = 1'b0;
    end else begin
      chk("excl", int'($onehot0({wrctrl, strctrl, shrctrl})
          && !(ready && busy) && (count <= W)), 1);
      if (wrctrl) begin
        n_str = 0;
        n_shr = 0;
      end
      if (strctrl) n_str++;
      if (shrctrl) n_shr++;
      if (ready && !rdy_prev) begin
        if (sb.size() == 0) begin
          chk("sb_empty", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("product", int'(prod[2*W-1:0]), e.prod);
          chk("latency", cyc - e.t0, e.lat);
          chk("adds", n_str, e.adds);
          chk("shifts", n_shr, W);
          chk("count_done", int'(count), W);
        end
      end
      rdy_prev = ready;
    end
  end

  task automatic start(input logic [W-1:0] mc,
                       input logic [W-1:0] mp);
    exp_t e;
    @(negedge clk);
    mcand  = mc;
    mplier = mp;
    e.prod = int'(mc) * int'(mp);
    e.adds = $countones(mp);
    e.lat  = 1 + 2 * W + e.adds;
    e.t0   = cyc + 1;
    sb.push_back(e);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("load_pulse", int'({wrctrl, busy, ready}), 3'b110);
    @(negedge clk);
    chk("count_clr", int'(count), 0);
  endtask

  task automatic wait_ready(input bit poke);
    int n = 0;
    while (!ready && n < 100) begin
      if (poke) run = ($urandom_range(0, 2) == 0);
      @(negedge clk);
      n++;
    end
    run = 1'b0;
    if (!ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic job(input logic [W-1:0] mc,
                     input logic [W-1:0] mp,
                     input bit poke);
    start(mc, mp);
    wait_ready(poke);
    @(negedge clk);
    chk("done_hold", int'({ready, busy}), 2'b10);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out", int'({wrctrl, strctrl, shrctrl, ready, busy}), 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_out", int'({wrctrl, strctrl, shrctrl, ready, busy}), 0);
    chk("idle_cnt", int'(count), 0);

    job(4'd7, 4'b0000, 1'b0);
    job(4'd9, 4'b1111, 1'b0);
    job(4'd12, 4'd10, 1'b0);
    for (int i = 0; i < 20; i++)
      job(4'($urandom), 4'($urandom), 1'($urandom));

    start(4'd5, 4'b1111);
    begin
      int n = 0;
      while (!strctrl && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("saw_add", int'(strctrl), 1);
    end
    rst = 1'b0;
    #1;
    chk("mid_rst", int'({wrctrl, strctrl, shrctrl, ready, busy}), 0);
    chk("mid_rst_cnt", int'(count), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("post_rst", int'({wrctrl, strctrl, shrctrl, ready, busy}), 0);
    job(4'd13, 4'd11, 1'b0);

`ifdef MUL_CTRL_ABORT_EN
    start(4'd6, 4'd3);
    begin
      int n = 0, s = 0;
      while (s < 2 && n < 50) begin
        @(negedge clk);
        if (shrctrl) s++;
        n++;
      end
      chk("saw_shift2", s, 2);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_out", int'({wrctrl, strctrl, shrctrl, ready, busy}), 0);
    chk("abort_cnt", int'(count), 0);
    repeat (12) @(negedge clk);
    chk("abort_idle", int'({ready, busy}), 0);
    sb.delete();
    job(4'd3, 4'd5, 1'b0);
`endif

    repeat (2) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_control.md
Name: mul_control

Overview:
- Sequencing FSM for the shift-add multiplier datapath. It drives the control side of the 64-bit product register: load, store ALU sum into the upper half, and shift right.
- Sits between the top-level start request and the product register and ALU. It samples the product LSB and emits one-cycle control pulses plus completion status.

Parameters:
- WIDTH, 32, multiplier operand width; number of iterations.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- run  input  1  start request, level-sampled in IDLE/DONE.
- lsb  input  1  product register bit 0 (current multiplier bit).
- wrctrl  output  1  one-cycle pulse: load operand into the product register.
- strctrl  output  1  one-cycle pulse: store the ALU result into the product upper half.
- shrctrl  output  1  one-cycle pulse: shift the product register right by 1.
- ready  output  1  product valid; high in DONE.
- busy  output  1  high in LOAD/TEST/ADD/SHIFT.
- count  output  CNT_W  iterations completed.

Behaviour:
- Reset (rst=0, async): state IDLE, count=0. wrctrl, strctrl, shrctrl, ready and busy are all 0. Reset mid-operation aborts immediately; no further pulses are issued.
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE. Outputs are Moore, decoded from registered state:
  - wrctrl=1 only in LOAD.
  - strctrl=1 only in ADD.
  - shrctrl=1 only in SHIFT.
  - ready=1 only in DONE.
- IDLE: run=1 -> LOAD; otherwise stay.
- LOAD: count<=0; -> TEST unconditionally.
- TEST: lsb sampled this edge. lsb=1 -> ADD; lsb=0 -> SHIFT.
- ADD: -> SHIFT.
- SHIFT: count<=count+1. If count==WIDTH-1 -> DONE; else -> TEST.
- DONE: ready held high, count holds WIDTH.
  - run=1 -> LOAD: restart; ready drops on that edge.
  - run=0 -> stay in DONE.
- run is ignored in LOAD/TEST/ADD/SHIFT; no queuing.
- Latency: the edge sampling run is edge 0. ready rises after edge 1 + 2*WIDTH + P, where P = number of 1 bits in the multiplier.
- Pulses are mutually exclusive: at most one of wrctrl, strctrl, shrctrl is high in any cycle.
- count never exceeds WIDTH; no wrap in normal operation.
- busy = (state is LOAD, TEST, ADD or SHIFT).

Optional Feature:
- Macro MUL_CTRL_ABORT_EN.
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 at a rising edge in LOAD, TEST, ADD or SHIFT -> IDLE next state and count<=0. No pulse is issued after that edge, and ready is not asserted.
  - abort in IDLE or DONE has no effect.
  - abort takes precedence over every transition.
- Undefined: no abort port; behaviour exactly as above.

Test Plan:
- WIDTH=4, reset low 2 cycles then released -> all outputs 0, count=0, stays IDLE with run=0.
- WIDTH=4, multiplier 4'b0000 (lsb held 0), run pulse:
  - wrctrl 1 cycle, then 4 shrctrl pulses, 0 strctrl.
  - ready rises after edge 9; count=4.
- WIDTH=4, multiplier 4'b1111 (lsb held 1):
  - 4 strctrl pulses, each immediately followed by a shrctrl pulse.
  - ready after edge 13.
- WIDTH=4, lsb sequence 0,1,0,1 per TEST -> strctrl only in iterations 2 and 4; ready after edge 11; multiplying 12 by 10 with the datapath gives product 120.
- run re-asserted while busy -> no effect. rst pulled low during ADD -> outputs 0 same cycle. run after release -> fresh LOAD with count=0.
- With MUL_CTRL_ABORT_EN: abort during iteration 2 SHIFT -> IDLE next cycle, ready never rises, busy=0.
